// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, credit-limited instruction fetch and decode buffer; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      pc_src_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_imm_i,
   input  logic [XLEN-1:0] ex_rs1_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [31:0]     imem_rsp_data_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] instr_pc_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_flushed_o,
`endif
   output logic            misalign_o
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] pc_q, pc_d, target;
   logic            started_q, started_d, misalign_q, misalign_d;
   logic [CW-1:0]   out_q, out_d, occ_q, occ_d, drop_q, drop_d;
   logic [AW-1:0]   bwr_q, bwr_d, brd_q, brd_d, fwr_q, fwr_d, frd_q, frd_d;
   logic            redirect, pop, accept, rsp_fire, rsp_drop, push;
   logic [31:0]     buf_instr_q [BUF_DEPTH];
   logic [XLEN-1:0] buf_pc_q [BUF_DEPTH];
   logic [XLEN-1:0] fifo_pc_q [BUF_DEPTH];
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]     fetched_q, fetched_d, flushed_q, flushed_d;
`endif

   // Redirect decode, credit check against buffer space, handshakes and next state
   always_comb begin
      redirect         = pc_src_i == 2'b01 || pc_src_i == 2'b10;
      target           = pc_src_i[1] ? (ex_rs1_i + ex_imm_i) & ~XLEN'(1) : ex_pc_i + ex_imm_i;
      instr_valid_o    = occ_q != '0;
      instr_o          = buf_instr_q[brd_q];
      instr_pc_o       = buf_pc_q[brd_q];
      misalign_o       = misalign_q;
      imem_addr_o      = pc_q;
      pop              = instr_valid_o && instr_ready_i && !redirect;
      imem_req_valid_o = started_q && !misalign_q && !redirect &&
                         (occ_q - CW'(pop) + out_q < CW'(BUF_DEPTH));
      accept           = imem_req_valid_o && imem_req_ready_i;
      rsp_fire         = imem_rsp_valid_i && out_q != '0;
      rsp_drop         = rsp_fire && (drop_q != '0 || redirect);
      push             = rsp_fire && !rsp_drop;
      started_d        = 1'b1;
      out_d            = out_q + CW'(accept) - CW'(rsp_fire);
      occ_d            = redirect ? '0 : occ_q + CW'(push) - CW'(pop);
      bwr_d            = bwr_q + AW'(push);
      brd_d            = redirect ? bwr_q : brd_q + AW'(pop);
      fwr_d            = fwr_q + AW'(accept);
      frd_d            = frd_q + AW'(rsp_fire);
      drop_d           = redirect ? out_d : drop_q - CW'(rsp_fire && drop_q != '0);
      pc_d             = redirect ? target : accept ? pc_q + XLEN'(4) : pc_q;
      misalign_d       = redirect ? target[1] : misalign_q;
`ifdef FETCH_PERF_CNT_EN
      fetched_d        = fetched_q + 32'(pop);
      flushed_d        = flushed_q + (redirect ? 32'(occ_q) : 32'd0) + 32'(rsp_drop);
      perf_fetched_o   = fetched_q;
      perf_flushed_o   = flushed_q;
`endif
   end

   // Control state; started_q delays the first request to the cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         started_q  <= 1'b0;
         misalign_q <= 1'b0;
         out_q      <= '0;
         occ_q      <= '0;
         drop_q     <= '0;
         bwr_q      <= '0;
         brd_q      <= '0;
         fwr_q      <= '0;
         frd_q      <= '0;
`ifdef FETCH_PERF_CNT_EN
         fetched_q  <= '0;
         flushed_q  <= '0;
`endif
      end else begin
         pc_q       <= pc_d;
         started_q  <= started_d;
         misalign_q <= misalign_d;
         out_q      <= out_d;
         occ_q      <= occ_d;
         drop_q     <= drop_d;
         bwr_q      <= bwr_d;
         brd_q      <= brd_d;
         fwr_q      <= fwr_d;
         frd_q      <= frd_d;
`ifdef FETCH_PERF_CNT_EN
         fetched_q  <= fetched_d;
         flushed_q  <= flushed_d;
`endif
      end
   end

   // Storage for in-flight request PCs and buffered words; pointers alone define validity
   always_ff @(posedge clk) begin
      if (accept) fifo_pc_q[fwr_q] <= pc_q;
      if (push) begin
         buf_instr_q[bwr_q] <= imem_rsp_data_i;
         buf_pc_q[bwr_q]    <= fifo_pc_q[frd_q];
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks plus randomized run checked against a program-order fetch model
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  pc_src_i = 2'b00;
   logic [31:0] ex_pc_i = '0, ex_imm_i = '0, ex_rs1_i = '0;
   logic        imem_req_ready_i = 1'b1, imem_rsp_valid_i = 1'b0, instr_ready_i = 1'b1;
   logic [31:0] imem_rsp_data_i = '0;
   logic        imem_req_valid_o, instr_valid_o, misalign_o;
   logic [31:0] imem_addr_o, instr_o, instr_pc_o;

   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        pend[$];
   int          cyc, lat, n_checks, n_fail;
   bit          rand_lat, inj_rsp;
   bit          did_fire, did_pop, saw_req, saw_mis;
   logic [31:0] fire_addr, pop_pc, pop_instr;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .pc_src_i(pc_src_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i),
      .ex_rs1_i(ex_rs1_i), .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
      .instr_pc_o(instr_pc_o), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a fixed function of address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // One clock cycle: memory model drives response, outputs sampled, then the edge
   task automatic step();
      int d;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      if (inj_rsp) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = 32'hDEAD_BEEF;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mem(pend[0].addr);
         void'(pend.pop_front());
      end
      #1;
      saw_req   = imem_req_valid_o;
      saw_mis   = misalign_o;
      did_fire  = imem_req_valid_o && imem_req_ready_i;
      fire_addr = imem_addr_o;
      did_pop   = instr_valid_o && instr_ready_i && !(pc_src_i == 2'b01 || pc_src_i == 2'b10);
      pop_pc    = instr_pc_o;
      pop_instr = instr_o;
      d = rand_lat ? int'($urandom_range(1, 3)) : lat;
      if (did_fire) pend.push_back('{fire_addr, cyc + d});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pc_src_i = 2'b00; ex_pc_i = '0; ex_imm_i = '0; ex_rs1_i = '0;
      imem_req_ready_i = 1'b1; instr_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
      inj_rsp = 1'b0; rand_lat = 1'b0; lat = 1;
      pend.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Run until the first request and first delivered instruction are seen (bounded)
   task automatic resume(output bit gf, output logic [31:0] fa, output bit gp,
                         output logic [31:0] pp, output logic [31:0] pi);
      gf = 1'b0; gp = 1'b0; fa = '0; pp = '0; pi = '0;
      for (int i = 0; i < 40 && !(gf && gp); i++) begin
         step();
         if (did_fire && !gf) begin gf = 1'b1; fa = fire_addr; end
         if (did_pop && !gp) begin gp = 1'b1; pp = pop_pc; pi = pop_instr; end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid_o); end
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid_o); end
      n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
      do_reset();
      step();
      n_checks++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_req: got %b want 0", saw_req); end
      step();
      n_checks++; if (!did_fire || fire_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_req: fire %b addr %h want 1 00000000", did_fire, fire_addr); end
   endtask

   task automatic test_free_run();
      logic [31:0] exp;
      do_reset();
      exp = 32'h0;
      for (int i = 0; i < 16; i++) begin
         step();
         n_checks++;
         if (i < 3) begin
            if (did_pop) begin n_fail++; $display("FAIL free_run_early_pop: cycle %0d pc %h", i, pop_pc); end
         end else begin
            if (!did_pop || pop_pc !== exp || pop_instr !== mem(exp)) begin
               n_fail++; $display("FAIL free_run_pop: cycle %0d pop %b pc %h instr %h want pc %h instr %h", i, did_pop, pop_pc, pop_instr, exp, mem(exp));
            end
            exp += 32'h4;
         end
      end
   endtask

   task automatic test_stall();
      int nf, np;
      logic [31:0] a [2];
      logic [31:0] want;
      do_reset();
      instr_ready_i = 1'b0;
      nf = 0;
      a[0] = '1; a[1] = '1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (did_fire) begin if (nf < 2) a[nf] = fire_addr; nf++; end
      end
      n_checks++; if (nf !== 2) begin n_fail++; $display("FAIL stall_req_count: got %0d want 2", nf); end
      n_checks++; if (a[0] !== 32'h0 || a[1] !== 32'h4) begin n_fail++; $display("FAIL stall_req_addrs: got %h %h want 00000000 00000004", a[0], a[1]); end
      instr_ready_i = 1'b1;
      np = 0;
      for (int i = 0; i < 20 && np < 3; i++) begin
         step();
         if (did_pop) begin
            want = 32'(np * 4);
            n_checks++;
            if (pop_pc !== want || pop_instr !== mem(want)) begin n_fail++; $display("FAIL stall_release_order: pc %h instr %h want %h %h", pop_pc, pop_instr, want, mem(want)); end
            np++;
         end
      end
      n_checks++; if (np !== 3) begin n_fail++; $display("FAIL stall_release_count: got %0d want 3", np); end
   endtask

   task automatic test_branch();
      bit gf, gp;
      logic [31:0] fa, pp, pi;
      int nf;
      do_reset();
      lat = 8;
      nf = 0;
      for (int i = 0; i < 4; i++) begin step(); if (did_fire) nf++; end
      n_checks++; if (nf !== 2) begin n_fail++; $display("FAIL branch_outstanding: got %0d want 2", nf); end
      lat = 1;
      pc_src_i = 2'b01; ex_pc_i = 32'h10; ex_imm_i = 32'hFFFF_FFF8;
      step();
      pc_src_i = 2'b00;
      n_checks++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL branch_req_during_redirect: got %b want 0", saw_req); end
      resume(gf, fa, gp, pp, pi);
      n_checks++; if (!gf || fa !== 32'h8) begin n_fail++; $display("FAIL branch_addr: seen %b got %h want 00000008", gf, fa); end
      n_checks++; if (!gp || pp !== 32'h8 || pi !== mem(32'h8)) begin n_fail++; $display("FAIL branch_instr: seen %b pc %h instr %h want 00000008 %h", gp, pp, pi, mem(32'h8)); end
   endtask

   task automatic test_jalr();
      bit gf, gp;
      logic [31:0] fa, pp, pi;
      do_reset();
      repeat (6) step();
      pc_src_i = 2'b10; ex_rs1_i = 32'h101; ex_imm_i = 32'h3;
      step();
      pc_src_i = 2'b00;
      resume(gf, fa, gp, pp, pi);
      n_checks++; if (!gf || fa !== 32'h104) begin n_fail++; $display("FAIL jalr_addr: seen %b got %h want 00000104", gf, fa); end
      n_checks++; if (!gp || pp !== 32'h104 || pi !== mem(32'h104)) begin n_fail++; $display("FAIL jalr_instr: seen %b pc %h instr %h want 00000104 %h", gp, pp, pi, mem(32'h104)); end
      step();
      n_checks++; if (!did_pop || pop_pc !== 32'h108) begin n_fail++; $display("FAIL jalr_next: pop %b pc %h want 00000108", did_pop, pop_pc); end
   endtask

   task automatic test_misalign();
      bit gf, gp;
      logic [31:0] fa, pp, pi;
      int nr, np;
      do_reset();
      repeat (5) step();
      pc_src_i = 2'b10; ex_rs1_i = 32'h100; ex_imm_i = 32'h2;
      step();
      pc_src_i = 2'b00;
      n_checks++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b want 1", misalign_o); end
      nr = 0; np = 0;
      for (int i = 0; i < 8; i++) begin step(); if (saw_req) nr++; if (did_pop) np++; end
      n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL misalign_no_req: got %0d requests want 0", nr); end
      n_checks++; if (np !== 0) begin n_fail++; $display("FAIL misalign_no_pop: got %0d pops want 0", np); end
      pc_src_i = 2'b01; ex_pc_i = 32'h200; ex_imm_i = 32'h0;
      step();
      pc_src_i = 2'b00;
      n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", misalign_o); end
      resume(gf, fa, gp, pp, pi);
      n_checks++; if (!gf || fa !== 32'h200) begin n_fail++; $display("FAIL misalign_resume_addr: seen %b got %h want 00000200", gf, fa); end
      n_checks++; if (!gp || pp !== 32'h200 || pi !== mem(32'h200)) begin n_fail++; $display("FAIL misalign_resume_instr: seen %b pc %h instr %h", gp, pp, pi); end
   endtask

   task automatic test_reset_mid();
      bit gf, gp;
      logic [31:0] fa, pp, pi;
      do_reset();
      lat = 2;
      repeat (6) step();
      rst_n = 1'b0;
      #1;
      n_checks++; if (imem_req_valid_o !== 1'b0 || instr_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_outputs: req %b instr %b mis %b want 0 0 0", imem_req_valid_o, instr_valid_o, misalign_o);
      end
      pend.delete();
      lat = 1;
      repeat (2) step();
      rst_n = 1'b1;
      inj_rsp = 1'b1;
      step();
      inj_rsp = 1'b0;
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_late_rsp: instr_valid %b want 0", instr_valid_o); end
      resume(gf, fa, gp, pp, pi);
      n_checks++; if (!gf || fa !== 32'h0) begin n_fail++; $display("FAIL mid_reset_restart_addr: seen %b got %h want 00000000", gf, fa); end
      n_checks++; if (!gp || pp !== 32'h0 || pi !== mem(32'h0)) begin n_fail++; $display("FAIL mid_reset_restart_instr: seen %b pc %h instr %h want 00000000 %h", gp, pp, pi, mem(32'h0)); end
   endtask

   task automatic test_random();
      logic [31:0] exp_f, exp_p, tgt, base;
      bit mis, redir;
      do_reset();
      rand_lat = 1'b1;
      exp_f = '0; exp_p = '0; mis = 1'b0;
      for (int i = 0; i < 600; i++) begin
         imem_req_ready_i = $urandom_range(0, 4) != 0;
         instr_ready_i    = $urandom_range(0, 3) != 0;
         redir            = $urandom_range(0, 19) == 0;
         pc_src_i = redir ? 2'($urandom_range(1, 2)) : ($urandom_range(0, 9) == 0 ? 2'b11 : 2'b00);
         tgt = {16'h0, 16'($urandom)} & ~32'h3;
         if ($urandom_range(0, 7) == 0) tgt[1] = 1'b1;
         base = $urandom;
         ex_pc_i  = base & ~32'h3;
         ex_rs1_i = base;
         ex_imm_i = pc_src_i == 2'b10 ? tgt - base + 32'($urandom_range(0, 1)) : tgt - ex_pc_i;
         step();
         n_checks++; if (saw_mis !== mis) begin n_fail++; $display("FAIL rand_misalign: cycle %0d got %b want %b", i, saw_mis, mis); end
         if (did_fire) begin
            n_checks++;
            if (mis || redir || fire_addr !== exp_f) begin n_fail++; $display("FAIL rand_req_addr: cycle %0d got %h want %h (mis %b redir %b)", i, fire_addr, exp_f, mis, redir); end
            exp_f += 32'h4;
         end
         if (did_pop) begin
            n_checks++;
            if (mis || pop_pc !== exp_p || pop_instr !== mem(exp_p)) begin n_fail++; $display("FAIL rand_pop: cycle %0d pc %h instr %h want %h %h", i, pop_pc, pop_instr, exp_p, mem(exp_p)); end
            exp_p += 32'h4;
         end
         n_checks++; if (pend.size() > 2) begin n_fail++; $display("FAIL rand_credit: cycle %0d outstanding %0d want <=2", i, pend.size()); end
         if (redir) begin exp_f = tgt; exp_p = tgt; mis = tgt[1]; end
      end
      pc_src_i = 2'b00;
   endtask

   initial begin
      cyc = 0; n_checks = 0; n_fail = 0; lat = 1; rand_lat = 1'b0; inj_rsp = 1'b0;
      test_reset();
      test_free_run();
      test_stall();
      test_branch();
      test_jalr();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
